// File: rtl/vmem_pkg.sv
// Shared types for the vector MEM stage: lane count, lane index and FSM state encoding.
package vmem_pkg;

  localparam int LANES = 8;

  typedef logic [2:0] lane_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    LAST,
    DONE
  } vmem_state_t;

endpackage

// File: rtl/vector_mem_stage_if.sv
// Word-wide synchronous data RAM port driven by the vector MEM stage (master) and the RAM (slave).
interface vector_mem_stage_if #(
  parameter int N      = 20,
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0] mem_addr;
  logic [N-1:0]      mem_wdata;
  logic              mem_we;
  logic [N-1:0]      mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/vmem_addr_gen.sv
// Lane address generator: base + idx*stride, wrapping modulo 2^ADDR_W.
module vmem_addr_gen
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] base,
  input  lane_idx_t         idx,
  input  logic [3:0]        stride,
  output logic [ADDR_W-1:0] addr
);

  // Largest offset is 7*15 = 105, which fits in 7 bits.
  logic [6:0] offset;

  assign offset = 7'(idx) * 7'(stride);
  assign addr   = base + ADDR_W'(offset);

endmodule

// File: rtl/vector_mem_stage.sv
// Vector MEM stage: serialises 8-lane loads/stores onto one word-wide sync RAM, one lane per cycle.
// Optional VMEM_STRIDE_EN adds a stride_i port; otherwise lanes sit at consecutive addresses.
module vector_mem_stage
  import vmem_pkg::*;
#(
  parameter int N      = 20,
  parameter int ADDR_W = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [LANES-1:0][N-1:0]   alu_result_i,
  input  logic [LANES-1:0][N-1:0]   write_data_i,
  input  logic [3:0]                wa3_i,
  input  logic                      reg_write_i,
  input  logic                      mem_to_reg_i,
  input  logic                      mem_write_i,
`ifdef VMEM_STRIDE_EN
  input  logic [3:0]                stride_i,
`endif
  vector_mem_stage_if.master        mem,
  output logic                      stall_o,
  output logic [LANES-1:0][N-1:0]   result_o,
  output logic [3:0]                wa3_o,
  output logic                      reg_write_o,
  output logic                      mem_to_reg_o
);

  vmem_state_t               state_reg, state_next;
  lane_idx_t                 idx_reg, idx_next;
  logic [LANES-1:0][N-1:0]   load_buf_reg;
  logic [LANES-1:0]          cap_sel;
  logic                      cap_en;
  lane_idx_t                 cap_lane;
  logic [3:0]                stride;
  logic [ADDR_W-1:0]         lane_addr;
  logic                      access_we;
  logic [ADDR_W-1:0]         access_addr;
  logic [N-1:0]              access_wdata;

`ifdef VMEM_STRIDE_EN
  assign stride = stride_i;
`else
  assign stride = 4'd1;
`endif

  // idx_reg is 0 whenever the FSM is in IDLE, so lane 0 issues from the same generator.
  vmem_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .base   (alu_result_i[0][ADDR_W-1:0]),
    .idx    (idx_reg),
    .stride (stride),
    .addr   (lane_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    access_we    = 1'b0;
    access_addr  = '0;
    access_wdata = '0;
    stall_o      = 1'b0;
    cap_en       = 1'b0;
    cap_lane     = idx_reg - 3'd1;
    case (state_reg)
      IDLE: begin
        if (mem_write_i) begin
          access_we    = 1'b1;
          access_addr  = lane_addr;
          access_wdata = write_data_i[0];
          idx_next     = 3'd1;
          state_next   = STORE;
          stall_o      = 1'b1;
        end else if (mem_to_reg_i) begin
          access_addr = lane_addr;
          idx_next    = 3'd1;
          state_next  = LOAD;
          stall_o     = 1'b1;
        end
      end
      STORE: begin
        access_we    = 1'b1;
        access_addr  = lane_addr;
        access_wdata = write_data_i[idx_reg];
        stall_o      = 1'b1;
        if (idx_reg == 3'd7) begin
          idx_next   = '0;
          state_next = DONE;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      LOAD: begin
        // Read data for the lane issued last cycle arrives now.
        access_addr = lane_addr;
        stall_o     = 1'b1;
        cap_en      = 1'b1;
        if (idx_reg == 3'd7) begin
          state_next = LAST;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      LAST: begin
        stall_o    = 1'b1;
        cap_en     = 1'b1;
        cap_lane   = 3'd7;
        idx_next   = '0;
        state_next = DONE;
      end
      DONE: begin
        idx_next   = '0;
        state_next = IDLE;
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_cap_sel
      assign cap_sel[gi] = cap_en && (cap_lane == lane_idx_t'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      load_buf_reg <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (cap_sel[i]) load_buf_reg[i] <= mem.mem_rdata;
      end
    end
  end

  // A reset landing mid-store must not let the in-flight lane reach the RAM.
  assign mem.mem_we    = access_we & ~reset;
  assign mem.mem_addr  = access_addr;
  assign mem.mem_wdata = access_wdata;

  assign result_o     = (mem_to_reg_i & ~mem_write_i) ? load_buf_reg : alu_result_i;
  assign wa3_o        = wa3_i;
  assign reg_write_o  = reg_write_i & ~stall_o;
  assign mem_to_reg_o = mem_to_reg_i & ~stall_o;

endmodule

// File: tb/tb_vector_mem_stage.sv
// Directed bench for vector_mem_stage with a behavioural sync RAM; define VMEM_STRIDE_EN for the stride case.
module tb_vector_mem_stage;
  import vmem_pkg::*;

  localparam int N  = 20;
  localparam int AW = 10;
  localparam int W  = LANES * N;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [LANES-1:0][N-1:0] alu_result_i;
  logic [LANES-1:0][N-1:0] write_data_i;
  logic [3:0]              wa3_i;
  logic                    reg_write_i;
  logic                    mem_to_reg_i;
  logic                    mem_write_i;
`ifdef VMEM_STRIDE_EN
  logic [3:0]              stride_i;
`endif
  logic                    stall_o;
  logic [LANES-1:0][N-1:0] result_o;
  logic [3:0]              wa3_o;
  logic                    reg_write_o;
  logic                    mem_to_reg_o;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] ram [0:(1<<AW)-1];

  always #5 clk = ~clk;

  vector_mem_stage_if #(.N(N), .ADDR_W(AW)) mem_bus ();

  vector_mem_stage #(.N(N), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result_i (alu_result_i),
    .write_data_i (write_data_i),
    .wa3_i        (wa3_i),
    .reg_write_i  (reg_write_i),
    .mem_to_reg_i (mem_to_reg_i),
    .mem_write_i  (mem_write_i),
`ifdef VMEM_STRIDE_EN
    .stride_i     (stride_i),
`endif
    .mem          (mem_bus.master),
    .stall_o      (stall_o),
    .result_o     (result_o),
    .wa3_o        (wa3_o),
    .reg_write_o  (reg_write_o),
    .mem_to_reg_o (mem_to_reg_o)
  );

  always @(posedge clk) begin
    if (mem_bus.mem_we) ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
    mem_bus.mem_rdata <= ram[mem_bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one memory op from IDLE through DONE and back to IDLE, checking every stalled cycle.
  task automatic run_op(input string name, input logic st, input logic ld,
                        input logic [LANES-1:0][N-1:0] alu, input logic [LANES-1:0][N-1:0] wd,
                        input logic [3:0] stride, input logic [LANES-1:0][N-1:0] exp_res,
                        input int exp_stall, input bit chk_clear);
    int n_stall;
    bit done_seen;
    logic [AW-1:0] base;
    logic [AW-1:0] ea;
    base         = alu[0][AW-1:0];
    alu_result_i = alu;
    write_data_i = wd;
    mem_write_i  = st;
    mem_to_reg_i = ld;
    reg_write_i  = 1'b1;
    wa3_i        = 4'd9;
`ifdef VMEM_STRIDE_EN
    stride_i     = stride;
`endif
    #1;
    n_stall   = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!stall_o) begin
        done_seen = 1'b1;
        break;
      end
      if (c == 0 && chk_clear) chk({name, "_buf_clear"}, W'(result_o), W'(0));
      n_stall++;
      if (c < LANES) begin
        ea = base + AW'(c) * AW'(stride);
        chk($sformatf("%s_addr%0d", name, c), W'(mem_bus.mem_addr), W'(ea));
        chk($sformatf("%s_we%0d", name, c), W'(mem_bus.mem_we), W'(st));
        if (st) chk($sformatf("%s_wdata%0d", name, c), W'(mem_bus.mem_wdata), W'(wd[c]));
      end else begin
        chk({name, "_last_we"}, W'(mem_bus.mem_we), W'(0));
        chk({name, "_last_addr"}, W'(mem_bus.mem_addr), W'(0));
      end
      chk($sformatf("%s_rw_bubble%0d", name, c), W'(reg_write_o), W'(0));
      @(posedge clk);
      #1;
    end
    chk({name, "_stall_cycles"}, W'(n_stall), W'(exp_stall));
    if (done_seen) begin
      chk({name, "_done_result"}, W'(result_o), W'(exp_res));
      chk({name, "_done_rw"}, W'(reg_write_o), W'(1));
      chk({name, "_done_m2r"}, W'(mem_to_reg_o), W'(ld));
      chk({name, "_done_we"}, W'(mem_bus.mem_we), W'(0));
      chk({name, "_done_wa3"}, W'(wa3_o), W'(9));
    end
    @(posedge clk);
    #1;
    mem_write_i  = 1'b0;
    mem_to_reg_i = 1'b0;
    #1;
    chk({name, "_idle_stall"}, W'(stall_o), W'(0));
  endtask

  logic [LANES-1:0][N-1:0] v_alu, v_wd, v_exp;
  logic [AW-1:0]           wrap_addr [LANES];

  initial begin
    reset        = 1'b1;
    alu_result_i = '0;
    write_data_i = '0;
    wa3_i        = 4'd0;
    reg_write_i  = 1'b0;
    mem_to_reg_i = 1'b0;
    mem_write_i  = 1'b0;
`ifdef VMEM_STRIDE_EN
    stride_i     = 4'd1;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", W'(stall_o), W'(0));
    chk("rst_we", W'(mem_bus.mem_we), W'(0));
    chk("rst_addr", W'(mem_bus.mem_addr), W'(0));
    chk("rst_wdata", W'(mem_bus.mem_wdata), W'(0));
    reset = 1'b0;

    // Plain ALU op: combinational pass-through, no stall.
    for (int i = 0; i < LANES; i++) alu_result_i[i] = 20'hABCDE;
    reg_write_i = 1'b1;
    wa3_i       = 4'd5;
    #1;
    v_exp = alu_result_i;
    chk("alu_result", W'(result_o), W'(v_exp));
    chk("alu_stall", W'(stall_o), W'(0));
    chk("alu_rw", W'(reg_write_o), W'(1));
    chk("alu_wa3", W'(wa3_o), W'(5));
    chk("alu_we", W'(mem_bus.mem_we), W'(0));
    chk("alu_addr", W'(mem_bus.mem_addr), W'(0));
    @(posedge clk);
    #1;

    // Store base 0x010, lane i = 0x1000+i.
    v_alu = '0;
    v_alu[0] = 20'h00010;
    for (int i = 0; i < LANES; i++) v_wd[i] = 20'h01000 + 20'(i);
    run_op("st010", 1'b1, 1'b0, v_alu, v_wd, 4'd1, v_alu, 8, 1'b0);
    for (int i = 0; i < LANES; i++)
      chk($sformatf("ram010_%0d", i), W'(ram[10'h010 + 10'(i)]), W'(20'h01000 + 20'(i)));

    // Load it back.
    run_op("ld010", 1'b0, 1'b1, v_alu, '0, 4'd1, v_wd, 9, 1'b0);

    // Store wrapping past the top of the address space.
    v_alu = '0;
    v_alu[0] = 20'h003FC;
    for (int i = 0; i < LANES; i++) v_wd[i] = 20'h02000 + 20'(i);
    run_op("stwrap", 1'b1, 1'b0, v_alu, v_wd, 4'd1, v_alu, 8, 1'b0);
    wrap_addr = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002, 10'h003};
    for (int i = 0; i < LANES; i++)
      chk($sformatf("ramwrap_%0d", i), W'(ram[wrap_addr[i]]), W'(20'h02000 + 20'(i)));

    // Store and load both set: store wins, result is the ALU vector.
    for (int i = 0; i < LANES; i++) v_alu[i] = 20'h50000 + 20'(i);
    v_alu[0] = 20'h00040;
    for (int i = 0; i < LANES; i++) v_wd[i] = 20'h03000 + 20'(i);
    run_op("both", 1'b1, 1'b1, v_alu, v_wd, 4'd1, v_alu, 8, 1'b0);
    chk("ram040_7", W'(ram[10'h047]), W'(20'h03007));

    // Reset during LOAD at idx 4 aborts; the partially filled buffer must be cleared.
    alu_result_i    = '0;
    alu_result_i[0] = 20'h00010;
    mem_to_reg_i    = 1'b1;
    reg_write_i     = 1'b1;
    #1;
    chk("abort_issue_stall", W'(stall_o), W'(1));
    repeat (4) @(posedge clk);
    #1;
    chk("abort_idx4_addr", W'(mem_bus.mem_addr), W'(10'h014));
    reset        = 1'b1;
    mem_to_reg_i = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_stall", W'(stall_o), W'(0));
    chk("abort_we", W'(mem_bus.mem_we), W'(0));
    chk("abort_addr", W'(mem_bus.mem_addr), W'(0));
    @(posedge clk);
    #1;
    chk("abort_no_done_stall", W'(stall_o), W'(0));
    v_alu = '0;
    v_alu[0] = 20'h00010;
    for (int i = 0; i < LANES; i++) v_exp[i] = 20'h01000 + 20'(i);
    run_op("ld_after_rst", 1'b0, 1'b1, v_alu, '0, 4'd1, v_exp, 9, 1'b1);

`ifdef VMEM_STRIDE_EN
    v_alu = '0;
    v_alu[0] = 20'h00020;
    for (int i = 0; i < LANES; i++) v_wd[i] = 20'h04000 + 20'(i);
    run_op("st_stride2", 1'b1, 1'b0, v_alu, v_wd, 4'd2, v_alu, 8, 1'b0);
    chk("ram_stride_02E", W'(ram[10'h02E]), W'(20'h04007));
    run_op("ld_stride0", 1'b0, 1'b1, v_alu, '0, 4'd0, {LANES{20'h04000}}, 9, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
